// File: rtl/mms_frame_ctrl.sv
// Frame controller: buffers 8 handshaked samples, then returns their max or min over a valid/ready output.
// Optional `define MMS_FRAME_INDEX_EN adds out_index, the position of the winning sample.
module mms_frame_ctrl #(
   parameter int DATA_W = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   input  logic              in_select,
   output logic              out_valid,
   input  logic              out_ready,
`ifdef MMS_FRAME_INDEX_EN
   output logic [DATA_W-1:0] out_result,
   output logic [2:0]        out_index
`else
   output logic [DATA_W-1:0] out_result
`endif
);

   typedef enum logic [1:0] {IDLE, FILL, CALC, HOLD} state_t;

   state_t            state, state_next;
   logic [2:0]        count, count_next;
   logic              sel, sel_next;
   logic              beat;
   logic [DATA_W-1:0] buffer [8];

   logic [3:0]        w1;
   logic [1:0]        w2;
   logic              w3;
   logic [DATA_W-1:0] v1 [4];
   logic [DATA_W-1:0] v2 [2];
   logic [DATA_W-1:0] v3;
`ifdef MMS_FRAME_INDEX_EN
   logic [2:0]        i1 [4];
   logic [2:0]        i2 [2];
   logic [2:0]        i3;
`endif

   // True when b should replace a; ties keep a, the lower index.
   function automatic logic wins(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b,
                                 input logic min_sel);
      return min_sel ? (b < a) : (b > a);
   endfunction

   assign in_ready  = (state == FILL);
   assign out_valid = (state == HOLD);
   assign beat      = in_valid && in_ready && !flush;

   always_comb begin
      state_next = state;
      count_next = count;
      sel_next   = sel;
      case (state)
         IDLE: state_next = FILL;
         FILL: begin
            if (beat) begin
               count_next = count + 3'd1;
               if (count == 3'd0) sel_next = in_select;
               if (count == 3'd7) state_next = CALC;
            end
         end
         CALC: state_next = HOLD;
         HOLD: if (out_ready) state_next = IDLE;
         default: state_next = IDLE;
      endcase
      if (flush) begin
         state_next = IDLE;
         count_next = 3'd0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         count <= 3'd0;
         sel   <= 1'b0;
      end else begin
         state <= state_next;
         count <= count_next;
         sel   <= sel_next;
      end
   end

   always_ff @(posedge clk) begin
      if (beat) buffer[count] <= in_data;
   end

   // Three-level comparator tree; the left operand always carries the lower index.
   always_comb begin
      for (int i = 0; i < 4; i++) begin
         w1[i] = wins(buffer[2*i], buffer[2*i+1], sel);
         v1[i] = w1[i] ? buffer[2*i+1] : buffer[2*i];
      end
      for (int i = 0; i < 2; i++) begin
         w2[i] = wins(v1[2*i], v1[2*i+1], sel);
         v2[i] = w2[i] ? v1[2*i+1] : v1[2*i];
      end
      w3 = wins(v2[0], v2[1], sel);
      v3 = w3 ? v2[1] : v2[0];
   end

`ifdef MMS_FRAME_INDEX_EN
   always_comb begin
      for (int i = 0; i < 4; i++) i1[i] = {2'(i), w1[i]};
      for (int i = 0; i < 2; i++) i2[i] = w2[i] ? i1[2*i+1] : i1[2*i];
      i3 = w3 ? i2[1] : i2[0];
   end
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_result <= '0;
`ifdef MMS_FRAME_INDEX_EN
         out_index  <= 3'd0;
`endif
      end else if (state == CALC && !flush) begin
         out_result <= v3;
`ifdef MMS_FRAME_INDEX_EN
         out_index  <= i3;
`endif
      end
   end

endmodule

// File: tb/tb_mms_frame_ctrl.sv
// Directed bench for mms_frame_ctrl: table of full-rate frames plus backpressure, gap, flush and reset sequences.
module tb_mms_frame_ctrl;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       flush = 1'b0;
   logic       in_valid = 1'b0;
   logic       in_ready;
   logic [7:0] in_data = 8'd0;
   logic       in_select = 1'b0;
   logic       out_valid;
   logic       out_ready = 1'b0;
   logic [7:0] out_result;
`ifdef MMS_FRAME_INDEX_EN
   logic [2:0] out_index;
`endif

   int n_tests = 0;
   int n_fail  = 0;

   mms_frame_ctrl #(.DATA_W(8)) dut (
      .clk(clk), .rst_n(rst_n), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_select(in_select),
      .out_valid(out_valid), .out_ready(out_ready),
`ifdef MMS_FRAME_INDEX_EN
      .out_result(out_result), .out_index(out_index)
`else
      .out_result(out_result)
`endif
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic            sel;
      logic [7:0][7:0] d;
      logic [7:0]      res;
      logic [2:0]      idx;
   } vec_t;

   vec_t vecs [6];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic set_vec(input int k, input logic s,
                          input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                          input logic [7:0] b3, input logic [7:0] b4, input logic [7:0] b5,
                          input logic [7:0] b6, input logic [7:0] b7,
                          input logic [7:0] r, input logic [2:0] x);
      vecs[k].sel  = s;
      vecs[k].d[0] = b0; vecs[k].d[1] = b1; vecs[k].d[2] = b2; vecs[k].d[3] = b3;
      vecs[k].d[4] = b4; vecs[k].d[5] = b5; vecs[k].d[6] = b6; vecs[k].d[7] = b7;
      vecs[k].res  = r;
      vecs[k].idx  = x;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_ready();
      int n = 0;
      while (!in_ready && n < 50) begin
         tick();
         n++;
      end
      if (!in_ready) chk("in_ready_timeout", 0, 1);
   endtask

   task automatic send_beat(input logic [7:0] d, input logic s);
      wait_ready();
      in_valid  = 1'b1;
      in_data   = d;
      in_select = s;
      tick();
      in_valid  = 1'b0;
   endtask

   // Later beats drive a toggling select, which must be ignored.
   task automatic feed(input logic s, input logic [7:0][7:0] d, input int gap, input logic [7:0] junk);
      for (int j = 0; j < 8; j++) begin
         send_beat(d[j], (j == 0) ? s : (((j % 2) == 1) ? ~s : s));
         in_data = junk;
         if (j < 7) begin
            for (int g = 0; g < gap; g++) begin
               in_select = ~in_select;
               tick();
            end
            chk("no_early_valid", out_valid, 0);
         end
      end
   endtask

   task automatic expect_result(input string tag, input logic [7:0] r, input logic [2:0] x);
      chk({tag, "_calc_valid"}, out_valid, 0);
      chk({tag, "_calc_ready"}, in_ready, 0);
      tick();
      chk({tag, "_valid"}, out_valid, 1);
      chk({tag, "_result"}, out_result, r);
`ifdef MMS_FRAME_INDEX_EN
      chk({tag, "_index"}, out_index, x);
`else
      if (x > 3'd7) chk({tag, "_index_range"}, x, 0);
`endif
   endtask

   task automatic handshake(input string tag);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      chk({tag, "_hs_valid"}, out_valid, 0);
      chk({tag, "_hs_idle_ready"}, in_ready, 0);
      tick();
      chk({tag, "_hs_ready"}, in_ready, 1);
   endtask

   logic [7:0][7:0] d;
   logic [7:0]      held;

   initial begin
      set_vec(0, 1'b0, 8'd3,  8'd200, 8'd7,  8'd15, 8'd0,  8'd255, 8'd9,  8'd1,   8'd255, 3'd5);
      set_vec(1, 1'b1, 8'd40, 8'd6,   8'd90, 8'd6,  8'd6,  8'd120, 8'd7,  8'd8,   8'd6,   3'd1);
      set_vec(2, 1'b0, 8'h77, 8'h77,  8'h77, 8'h77, 8'h77, 8'h77,  8'h77, 8'h77,  8'h77,  3'd0);
      set_vec(3, 1'b1, 8'd9,  8'd8,   8'd7,  8'd6,  8'd5,  8'd4,   8'd3,  8'd0,   8'd0,   3'd7);
      set_vec(4, 1'b0, 8'd0,  8'd0,   8'd0,  8'd0,  8'd0,  8'd0,   8'd0,  8'd1,   8'd1,   3'd7);
      set_vec(5, 1'b1, 8'd255,8'd255, 8'd254,8'd255,8'd255,8'd255, 8'd255,8'd254, 8'd254, 3'd2);

      #2;
      chk("rst_in_ready", in_ready, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_result", out_result, 0);
`ifdef MMS_FRAME_INDEX_EN
      chk("rst_out_index", out_index, 0);
`endif
      tick();
      tick();
      rst_n = 1'b1;
      chk("post_rst_not_ready", in_ready, 0);
      tick();
      chk("first_ready", in_ready, 1);

      for (int k = 0; k < 6; k++) begin
         feed(vecs[k].sel, vecs[k].d, 0, 8'h00);
         expect_result($sformatf("vec%0d", k), vecs[k].res, vecs[k].idx);
         handshake($sformatf("vec%0d", k));
      end

      // Backpressure: HOLD for 5 cycles with the producer still pushing.
      set_vec(0, 1'b0, 8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8, 8'd8, 3'd7);
      feed(vecs[0].sel, vecs[0].d, 0, 8'h00);
      expect_result("bp", 8'd8, 3'd7);
      held = out_result;
      in_valid = 1'b1;
      in_data  = 8'hEE;
      for (int c = 0; c < 5; c++) begin
         tick();
         chk("bp_valid", out_valid, 1);
         chk("bp_result", out_result, held);
         chk("bp_in_ready", in_ready, 0);
      end
      in_valid = 1'b0;
      handshake("bp");

      // Gapped input with junk on in_data between beats.
      set_vec(0, 1'b0, 8'd5, 8'd17, 8'd3, 8'd99, 8'd99, 8'd2, 8'd50, 8'd1, 8'd99, 3'd3);
      feed(vecs[0].sel, vecs[0].d, 2, 8'hFF);
      expect_result("gap", 8'd99, 3'd3);
      handshake("gap");

      // Flush after 5 beats, with a beat offered in the flush cycle.
      for (int j = 0; j < 5; j++) send_beat(8'h01, 1'b0);
      flush    = 1'b1;
      in_valid = 1'b1;
      in_data  = 8'h00;
      tick();
      flush    = 1'b0;
      in_valid = 1'b0;
      chk("flush_valid", out_valid, 0);
      chk("flush_ready", in_ready, 0);
      for (int j = 0; j < 8; j++) d[j] = (j == 6) ? 8'h02 : 8'h10;
      feed(1'b1, d, 0, 8'h00);
      expect_result("flush", 8'h02, 3'd6);
      handshake("flush");

      // Asynchronous reset while a result is held.
      set_vec(0, 1'b0, 8'h80, 8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'h80, 3'd0);
      feed(vecs[0].sel, vecs[0].d, 0, 8'h00);
      expect_result("rsthold", 8'h80, 3'd0);
      #2;
      rst_n = 1'b0;
      #1;
      chk("rsthold_valid", out_valid, 0);
      chk("rsthold_result", out_result, 0);
      chk("rsthold_ready", in_ready, 0);
      tick();
      tick();
      rst_n = 1'b1;
      chk("rsthold_rel_ready", in_ready, 0);
      tick();
      chk("rsthold_first_ready", in_ready, 1);
      feed(vecs[2].sel, vecs[2].d, 0, 8'h00);
      expect_result("after_rst", 8'h77, 3'd0);
      handshake("after_rst");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got 0 expected 1");
      $fatal(1, "timeout");
   end

endmodule
